// File: rtl/insn_queue_pkg.sv
// Shared constants and helpers for the instruction queue.
// Widths, depth, branch-flag bit index and the valid-mask decoder.
package insn_queue_pkg;

  localparam int INSN_WIDTH  = 99;
  localparam int IQ_DEPTH    = 16;
  localparam int IQ_PTR_W    = 4;
  localparam int BR_FLAG_BIT = 9;

  typedef logic [INSN_WIDTH-1:0] insn_t;

  // Leading ones from bit3; anything after the first zero is ignored.
  function automatic logic [2:0] lead_ones(input logic [3:0] v);
    logic [2:0] n;
    n = 3'd0;
    unique case (1'b1)
      (v[3] == 1'b0):      n = 3'd0;
      (v[3:2] == 2'b10):   n = 3'd1;
      (v[3:1] == 3'b110):  n = 3'd2;
      (v == 4'b1110):      n = 3'd3;
      (v == 4'b1111):      n = 3'd4;
      default:             n = 3'd0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/insn_queue_storage.sv
// iq_storage: DEPTH x INSN_WIDTH register array, 4 consecutive write
// ports (first i_wr_n used) and 2 async reads at rd_ptr and rd_ptr+1.
module iq_storage #(
  parameter int INSN_WIDTH = 99,
  parameter int DEPTH      = 16,
  parameter int PTR_W      = 4
) (
  input  logic                      i_Clk,
  input  logic [PTR_W-1:0]          i_wr_ptr,
  input  logic [2:0]                i_wr_n,
  input  logic [3:0][INSN_WIDTH-1:0] i_wdata,
  input  logic [PTR_W-1:0]          i_rd_ptr,
  output logic [INSN_WIDTH-1:0]     o_rd0,
  output logic [INSN_WIDTH-1:0]     o_rd1
);

  logic [INSN_WIDTH-1:0] mem_q [DEPTH];
  logic [INSN_WIDTH-1:0] mem_d [DEPTH];

  // Slot k goes to wr_ptr+k; the PTR_W-bit sum wraps on its own.
  always_comb begin
    mem_d = mem_q;
    for (int k = 0; k < 4; k++) begin
      if (k < int'(i_wr_n)) begin
        mem_d[i_wr_ptr + PTR_W'(k)] = i_wdata[k];
      end
    end
  end

  // Contents are not reset; pointers and count make stale data invisible.
  always_ff @(posedge i_Clk) begin
    mem_q <= mem_d;
  end

  assign o_rd0 = mem_q[i_rd_ptr];
  assign o_rd1 = mem_q[i_rd_ptr + PTR_W'(1)];

endmodule

// File: rtl/insn_queue.sv
// insn_queue: circular queue between fetch aligner and issue.
// Enqueues 0-4/cycle, presents 2 oldest, stall and flush control.
module insn_queue #(
  parameter int INSN_WIDTH = insn_queue_pkg::INSN_WIDTH,
  parameter int DEPTH      = insn_queue_pkg::IQ_DEPTH,
  parameter int PTR_W      = insn_queue_pkg::IQ_PTR_W
) (
  input  logic                  i_Clk,
  input  logic                  i_Reset,
  input  logic                  i_Flush,
  input  logic [3:0]            i_valid,
  input  logic [INSN_WIDTH-1:0] i_isn1,
  input  logic [INSN_WIDTH-1:0] i_isn2,
  input  logic [INSN_WIDTH-1:0] i_isn3,
  input  logic [INSN_WIDTH-1:0] i_isn4,
  output logic                  o_Stall,
  input  logic [1:0]            i_deq,
  output logic [1:0]            o_head_valid,
  output logic [INSN_WIDTH-1:0] o_head1,
  output logic [INSN_WIDTH-1:0] o_head2,
  output logic [PTR_W:0]        o_count
);

  import insn_queue_pkg::*;

  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]   count_q, count_d;

  logic [2:0]       n_enq;
  logic [2:0]       n_wr;
  logic             enq_fire;
  logic [1:0]       deq_req;
  logic [1:0]       n_deq;
  logic [PTR_W:0]   free_cnt;
  logic [INSN_WIDTH-1:0] rd0, rd1;

  assign n_enq = lead_ones(i_valid);

  // Stall looks at registered count only: no path from i_deq.
  assign free_cnt = (PTR_W+1)'(DEPTH) - count_q;
  assign o_Stall  = free_cnt < (PTR_W+1)'(4);

  assign enq_fire = (n_enq != 3'd0) && !o_Stall && !i_Flush;
  assign n_wr     = (enq_fire && !i_Reset) ? n_enq : 3'd0;

  // 3 is illegal and behaves as 2; never pop past the current count.
  assign deq_req = (i_deq == 2'd3) ? 2'd2 : i_deq;
  assign n_deq   = ((PTR_W+1)'(deq_req) > count_q) ? count_q[1:0]
                                                   : deq_req;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (i_Flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      rd_ptr_d = rd_ptr_q + PTR_W'(n_deq);
      wr_ptr_d = wr_ptr_q + PTR_W'(n_wr);
      count_d  = count_q + (PTR_W+1)'(n_wr)
                         - (PTR_W+1)'(n_deq);
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge i_Clk) begin
    if (!i_Reset) begin
      assert (i_deq != 2'd3);
    end
  end

  iq_storage #(
    .INSN_WIDTH (INSN_WIDTH),
    .DEPTH      (DEPTH),
    .PTR_W      (PTR_W)
  ) u_storage (
    .i_Clk    (i_Clk),
    .i_wr_ptr (wr_ptr_q),
    .i_wr_n   (n_wr),
    .i_wdata  ({i_isn4, i_isn3, i_isn2, i_isn1}),
    .i_rd_ptr (rd_ptr_q),
    .o_rd0    (rd0),
    .o_rd1    (rd1)
  );

  assign o_head_valid[1] = count_q >= (PTR_W+1)'(1);
  assign o_head_valid[0] = count_q >= (PTR_W+1)'(2);
  assign o_head1 = o_head_valid[1] ? rd0 : '0;
  assign o_head2 = o_head_valid[0] ? rd1 : '0;
  assign o_count = count_q;

endmodule

// File: tb/tb_insn_queue.sv
// Self-checking bench for insn_queue with a queue scoreboard.
// Directed steps; outputs checked on the falling edge.
module tb_insn_queue;

  localparam int W = 99;

  logic         clk;
  logic         rst;
  logic         flush;
  logic [3:0]   valid;
  logic [W-1:0] isn1, isn2, isn3, isn4;
  logic         stall;
  logic [1:0]   deq;
  logic [1:0]   head_valid;
  logic [W-1:0] head1, head2;
  logic [4:0]   count;

  int tests;
  int fails;

  logic [W-1:0] sb [$];

  insn_queue dut (
    .i_Clk        (clk),
    .i_Reset      (rst),
    .i_Flush      (flush),
    .i_valid      (valid),
    .i_isn1       (isn1),
    .i_isn2       (isn2),
    .i_isn3       (isn3),
    .i_isn4       (isn4),
    .o_Stall      (stall),
    .i_deq        (deq),
    .o_head_valid (head_valid),
    .o_head1      (head1),
    .o_head2      (head2),
    .o_count      (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [W-1:0] obs,
                     input logic [W-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] rnd_insn();
    logic [127:0] r;
    r = {$urandom, $urandom, $urandom, $urandom};
    return r[W-1:0];
  endfunction

  // Compare DUT state with the scoreboard (called mid-cycle).
  task automatic chk_state(input string tag);
    int n;
    logic [W-1:0] e1, e2;
    n  = sb.size();
    e1 = (n >= 1) ? sb[0] : '0;
    e2 = (n >= 2) ? sb[1] : '0;
    chk({tag, ".count"}, W'(count), W'(n));
    chk({tag, ".stall"}, W'(stall), W'((16 - n) < 4));
    chk({tag, ".hv"}, W'(head_valid), W'({n >= 1, n >= 2}));
    chk({tag, ".head1"}, head1, e1);
    chk({tag, ".head2"}, head2, e2);
  endtask

  // One cycle: check current state, drive inputs, update model, clock.
  task automatic step(input string tag, input logic [3:0] v,
                      input logic [1:0] d, input logic fl,
                      input logic rs);
    int n, ne, nd;
    logic st;
    logic [W-1:0] ins [4];
    logic [W-1:0] popped;
    @(negedge clk);
    chk_state(tag);
    for (int k = 0; k < 4; k++) ins[k] = rnd_insn();
    isn1  = ins[0];
    isn2  = ins[1];
    isn3  = ins[2];
    isn4  = ins[3];
    valid = v;
    deq   = d;
    flush = fl;
    rst   = rs;
    n  = sb.size();
    st = (16 - n) < 4;
    ne = 0;
    while (ne < 4 && v[3 - ne]) ne++;
    nd = (int'(d) < n) ? int'(d) : n;
    if (rs || fl) begin
      sb.delete();
    end else begin
      for (int k = 0; k < nd; k++) begin
        popped = sb.pop_front();
        chk({tag, ".pop"}, (k == 0) ? head1 : head2, popped);
      end
      if (!st) begin
        for (int k = 0; k < ne; k++) sb.push_back(ins[k]);
      end
    end
    @(posedge clk);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst   = 1'b1;
    flush = 1'b0;
    valid = 4'b0;
    deq   = 2'd0;
    isn1  = '0;
    isn2  = '0;
    isn3  = '0;
    isn4  = '0;
    @(posedge clk);
    @(posedge clk);

    step("rst", 4'b0000, 2'd0, 1'b0, 1'b1);
    step("idle", 4'b0000, 2'd0, 1'b0, 1'b0);
    step("deq_empty", 4'b0000, 2'd2, 1'b0, 1'b0);

    step("fill0", 4'b1111, 2'd0, 1'b0, 1'b0);
    step("fill1", 4'b1111, 2'd0, 1'b0, 1'b0);
    step("fill2", 4'b1111, 2'd0, 1'b0, 1'b0);
    step("fill3", 4'b1111, 2'd0, 1'b0, 1'b0);
    step("full_refuse", 4'b1111, 2'd0, 1'b0, 1'b0);
    step("full_hold", 4'b0000, 2'd0, 1'b0, 1'b0);
    step("flush_full", 4'b0000, 2'd0, 1'b1, 1'b0);

    step("mix1100", 4'b1100, 2'd0, 1'b0, 1'b0);
    step("mix1000", 4'b1000, 2'd0, 1'b0, 1'b0);
    step("mix1010", 4'b1010, 2'd0, 1'b0, 1'b0);
    step("mix1110", 4'b1110, 2'd0, 1'b0, 1'b0);
    step("mix0xxx", 4'b0111, 2'd2, 1'b0, 1'b0);
    step("drain2", 4'b0000, 2'd2, 1'b0, 1'b0);
    step("drain2b", 4'b0000, 2'd2, 1'b0, 1'b0);
    step("drain1", 4'b0000, 2'd1, 1'b0, 1'b0);

    // Pointers now at 7; advance both to 14 with count 0.
    step("pre1", 4'b1111, 2'd0, 1'b0, 1'b0);
    step("pre2", 4'b1110, 2'd2, 1'b0, 1'b0);
    step("pre3", 4'b0000, 2'd2, 1'b0, 1'b0);
    step("pre4", 4'b0000, 2'd2, 1'b0, 1'b0);
    step("pre5", 4'b0000, 2'd1, 1'b0, 1'b0);
    step("wrap_enq", 4'b1111, 2'd0, 1'b0, 1'b0);
    step("wrap_deq1", 4'b0000, 2'd2, 1'b0, 1'b0);
    step("wrap_deq2", 4'b0000, 2'd2, 1'b0, 1'b0);

    step("to12a", 4'b1111, 2'd0, 1'b0, 1'b0);
    step("to12b", 4'b1111, 2'd0, 1'b0, 1'b0);
    step("to12c", 4'b1111, 2'd0, 1'b0, 1'b0);
    step("sim12", 4'b1111, 2'd2, 1'b0, 1'b0);
    step("sim14", 4'b1111, 2'd2, 1'b0, 1'b0);
    step("sim12b", 4'b1111, 2'd1, 1'b0, 1'b0);

    // From 15: bring to 9 then flush with traffic.
    step("to9a", 4'b0000, 2'd2, 1'b0, 1'b0);
    step("to9b", 4'b0000, 2'd2, 1'b0, 1'b0);
    step("to9c", 4'b0000, 2'd2, 1'b0, 1'b0);
    step("flush9", 4'b1111, 2'd2, 1'b1, 1'b0);
    step("refill4", 4'b1111, 2'd0, 1'b0, 1'b0);
    step("refill1", 4'b1000, 2'd0, 1'b0, 1'b0);
    step("reset5", 4'b1111, 2'd1, 1'b0, 1'b1);
    step("post_rst", 4'b1100, 2'd0, 1'b0, 1'b0);

    @(negedge clk);
    chk_state("final");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
